// File: rtl/snake_pkg.sv
// Shared direction type, reset heading and turn-queue depth for the snake direction controller.
// Define SNAKE_DIR_QUEUE2_EN to get a two-entry turn queue; otherwise the queue holds one turn.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam dir_t RST_DIR = DIR_RIGHT;

`ifdef SNAKE_DIR_QUEUE2_EN
    localparam int QUEUE_DEPTH = 2;
`else
    localparam int QUEUE_DEPTH = 1;
`endif

    // Opposite pairs differ only in the low bit of the encoding.
    function automatic dir_t opposite_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// Small shift-register queue of pending headings; entry 0 is the head, level-1 the tail.
// Pop is applied before push, so a full queue can accept a push in the same cycle it pops.
module snake_dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             push,
    input  logic                             pop,
    input  logic [1:0]                       din,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       level,
    output logic [1:0]                       head,
    output logic [1:0]                       tail
);

    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [LVL_W-1:0] lvl_after_pop;
    logic             pop_ok;
    logic             push_ok;
    logic [1:0]       mem_q     [DEPTH];
    logic [1:0]       shift_src [DEPTH];
    logic [1:0]       tail_sel;

    assign pop_ok        = pop && (level_q != '0);
    assign lvl_after_pop = level_q - LVL_W'(pop_ok);
    assign push_ok       = push && (lvl_after_pop != LVL_W'(DEPTH));

    always_comb begin
        level_d = lvl_after_pop + LVL_W'(push_ok);
        if (flush) begin
            level_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // On a pop every entry takes its successor; the last entry has none and keeps its value.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
        if (gi < DEPTH - 1) begin : g_mid
            assign shift_src[gi] = mem_q[gi+1];
        end else begin : g_last
            assign shift_src[gi] = mem_q[gi];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && (lvl_after_pop == LVL_W'(i))) begin
                mem_q[i] <= din;
            end else if (pop_ok) begin
                mem_q[i] <= shift_src[i];
            end
        end
    end

    always_comb begin
        tail_sel = mem_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LVL_W'(i + 1)) begin
                tail_sel = mem_q[i];
            end
        end
    end

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[0];
    assign tail  = tail_sel;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: move-period counter, key arbitration and a turn queue popped on each move.
// Queue depth follows SNAKE_DIR_QUEUE2_EN through snake_pkg.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int MOVE_PERIOD = 5_000_000,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_run,
    input  logic       left_key_press,
    input  logic       right_key_press,
    input  logic       up_key_press,
    input  logic       down_key_press,
    output logic [1:0] dir,
    output logic       move_tick,
    output logic       dir_changed
);

    localparam int LVL_W = $clog2(QUEUE_DEPTH + 1);

    dir_t             dir_q;
    dir_t             dir_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             move_tick_q;
    logic             dir_changed_q;

    logic             move_event;
    logic             req_valid;
    dir_t             req_dir;
    dir_t             ref_dir;
    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic [LVL_W-1:0] q_level;
    logic [LVL_W-1:0] lvl_after_pop;
    logic [1:0]       q_head;
    logic [1:0]       q_tail;

    // Only one press per cycle survives: UP > DOWN > LEFT > RIGHT.
    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_UP;
        if (up_key_press) begin
            req_dir = DIR_UP;
        end else if (down_key_press) begin
            req_dir = DIR_DOWN;
        end else if (left_key_press) begin
            req_dir = DIR_LEFT;
        end else if (right_key_press) begin
            req_dir = DIR_RIGHT;
        end else begin
            req_valid = 1'b0;
        end
    end

    always_comb begin
        move_event = game_run && (cnt_q == CNT_W'(MOVE_PERIOD - 1));
        if (!game_run || move_event) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A request is judged against the heading the snake will have once queued turns are applied.
    always_comb begin
        q_pop         = move_event && !q_empty;
        dir_d         = q_pop ? dir_t'(q_head) : dir_q;
        lvl_after_pop = q_level - LVL_W'(q_pop);
        ref_dir       = (lvl_after_pop != '0) ? dir_t'(q_tail) : dir_d;
        q_push        = game_run && req_valid
                        && (req_dir != ref_dir)
                        && (req_dir != opposite_dir(ref_dir))
                        && !(q_full && !q_pop);
    end

    snake_dir_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (!game_run),
        .push  (q_push),
        .pop   (q_pop),
        .din   (req_dir),
        .full  (q_full),
        .empty (q_empty),
        .level (q_level),
        .head  (q_head),
        .tail  (q_tail)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q         <= RST_DIR;
            cnt_q         <= '0;
            move_tick_q   <= 1'b0;
            dir_changed_q <= 1'b0;
        end else begin
            dir_q         <= dir_d;
            cnt_q         <= cnt_d;
            move_tick_q   <= move_event;
            dir_changed_q <= q_pop;
        end
    end

    assign dir         = dir_q;
    assign move_tick   = move_tick_q;
    assign dir_changed = dir_changed_q;

endmodule
